// File: rtl/sort_swap_unit.sv
// Compare-and-swap engine: reads two words from a single-port synchronous memory,
// compares them and writes them back exchanged when they are out of order.
module sort_swap_unit #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5,
    parameter int ASCEND    = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] a,
    input  logic [ADDRWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 done,
    output logic                 swapped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDRWIDTH-1:0]   r_a;
    logic [ADDRWIDTH-1:0]   r_b;
    logic [DATAWIDTH-1:0]   r_val_a;
    logic [ADDRWIDTH-1:0]   r_mem_addr;
    logic [DATAWIDTH-1:0]   r_mem_wdata;
    logic                   r_swapped;
    logic                   w_swap;

    // In CMP the second operand is still on mem_rdata; the first is in r_val_a.
    assign w_swap = (r_a != r_b) &&
                    ((ASCEND != 0) ? (r_val_a > mem_rdata) : (r_val_a < mem_rdata));

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RD_A;
            S_RD_A:  w_next = S_RD_B;
            S_RD_B:  w_next = S_CMP;
            S_CMP:   w_next = w_swap ? S_WR_A : S_DONE;
            S_WR_A:  w_next = S_WR_B;
            S_WR_B:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Address and write data are loaded one state early so they are registered
    // outputs that are already valid throughout the state that uses them.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_val_a     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_swapped   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_swapped  <= 1'b0;
                        r_mem_addr <= a;
                    end
                end
                S_RD_A: r_mem_addr <= r_b;
                S_RD_B: r_val_a <= mem_rdata;
                S_CMP: begin
                    if (w_swap) begin
                        r_mem_addr  <= r_a;
                        r_mem_wdata <= mem_rdata;
                    end
                end
                S_WR_A: begin
                    r_swapped   <= 1'b1;
                    r_mem_addr  <= r_b;
                    r_mem_wdata <= r_val_a;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from state so an asynchronous reset removes them at once.
    assign mem_we    = (r_state == S_WR_A) || (r_state == S_WR_B);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign swapped   = r_swapped;

endmodule

// File: tb/tb_sort_swap_unit.sv
// Bench for sort_swap_unit: one ascending and one descending instance, each on its
// own synchronous memory, checked against an array model of the sort memory.
module tb_sort_swap_unit;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start [2];
    logic [AW-1:0] a_in  [2];
    logic [AW-1:0] b_in  [2];
    logic [DW-1:0] rdata [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] wdata [2];
    logic          we    [2];
    logic          busy  [2];
    logic          done  [2];
    logic          swp   [2];

    logic [DW-1:0] mem0 [32];
    logic [DW-1:0] mem1 [32];
    logic [DW-1:0] ref_mem [2][32];

    logic          pk_en   = 1'b0;
    logic          pk_sel  = 1'b0;
    logic [AW-1:0] pk_addr = '0;
    logic [DW-1:0] pk_data = '0;

    int checks   = 0;
    int failures = 0;

    sort_swap_unit #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .ASCEND(1)) u_asc (
        .Clk(clk), .Rst(rst), .start(start[0]), .a(a_in[0]), .b(b_in[0]),
        .mem_rdata(rdata[0]), .mem_addr(maddr[0]), .mem_wdata(wdata[0]),
        .mem_we(we[0]), .busy(busy[0]), .done(done[0]), .swapped(swp[0])
    );

    sort_swap_unit #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .ASCEND(0)) u_desc (
        .Clk(clk), .Rst(rst), .start(start[1]), .a(a_in[1]), .b(b_in[1]),
        .mem_rdata(rdata[1]), .mem_addr(maddr[1]), .mem_wdata(wdata[1]),
        .mem_we(we[1]), .busy(busy[1]), .done(done[1]), .swapped(swp[1])
    );

    always @(posedge clk) begin
        if (we[0]) mem0[maddr[0]] <= wdata[0];
        else if (pk_en && !pk_sel) mem0[pk_addr] <= pk_data;
        rdata[0] <= mem0[maddr[0]];
    end

    always @(posedge clk) begin
        if (we[1]) mem1[maddr[1]] <= wdata[1];
        else if (pk_en && pk_sel) mem1[pk_addr] <= pk_data;
        rdata[1] <= mem1[maddr[1]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] peek(input int s, input int ad);
        return (s != 0) ? mem1[ad] : mem0[ad];
    endfunction

    task automatic poke(input int s, input int ad, input logic [DW-1:0] d);
        @(negedge clk);
        pk_en   = 1'b1;
        pk_sel  = (s != 0);
        pk_addr = AW'(ad);
        pk_data = d;
        @(posedge clk);
        #1 pk_en = 1'b0;
        ref_mem[s][ad] = d;
    endtask

    // Issues one pair and checks latency, write traffic, flags and final memory.
    task automatic run_op(input int s, input int ta, input int tb_, input bit junk, input string tag);
        logic [DW-1:0] va, vb;
        bit            exp_sw;
        int            nw, dcyc, bad_busy;
        logic          sw_obs;
        logic [AW-1:0] w_addr [2];
        logic [DW-1:0] w_dat  [2];
        int            w_cyc  [2];
        va     = ref_mem[s][ta];
        vb     = ref_mem[s][tb_];
        exp_sw = (ta != tb_) && ((s == 0) ? (va > vb) : (va < vb));
        nw = 0; dcyc = -1; bad_busy = 0; sw_obs = 1'b0;
        for (int i = 0; i < 2; i++) begin w_addr[i] = '0; w_dat[i] = '0; w_cyc[i] = -1; end

        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy[s]), 32'd0);
        start[s] = 1'b1;
        a_in[s]  = AW'(ta);
        b_in[s]  = AW'(tb_);
        for (int k = 1; k <= 12 && dcyc < 0; k++) begin
            @(negedge clk);
            if (busy[s] !== 1'b1) bad_busy++;
            if (we[s] === 1'b1) begin
                if (nw < 2) begin
                    w_addr[nw] = maddr[s];
                    w_dat[nw]  = wdata[s];
                    w_cyc[nw]  = k;
                end
                nw++;
            end
            if (done[s] === 1'b1) begin
                dcyc   = k;
                sw_obs = swp[s];
            end
            start[s] = junk && (dcyc < 0);
            if (junk) begin
                a_in[s] = AW'($urandom_range(0, 31));
                b_in[s] = AW'($urandom_range(0, 31));
            end
        end
        start[s] = 1'b0;

        check({tag, "_done_cycle"}, 32'(dcyc), exp_sw ? 32'd6 : 32'd4);
        check({tag, "_swapped"}, 32'(sw_obs), 32'(exp_sw));
        check({tag, "_nwrites"}, 32'(nw), exp_sw ? 32'd2 : 32'd0);
        check({tag, "_busy"}, 32'(bad_busy), 32'd0);
        if (exp_sw) begin
            check({tag, "_wr0_addr"}, 32'(w_addr[0]), 32'(ta));
            check({tag, "_wr0_data"}, w_dat[0], vb);
            check({tag, "_wr0_cyc"}, 32'(w_cyc[0]), 32'd4);
            check({tag, "_wr1_addr"}, 32'(w_addr[1]), 32'(tb_));
            check({tag, "_wr1_data"}, w_dat[1], va);
            check({tag, "_wr1_cyc"}, 32'(w_cyc[1]), 32'd5);
            ref_mem[s][ta]  = vb;
            ref_mem[s][tb_] = va;
        end
        check({tag, "_mem_a"}, peek(s, ta), ref_mem[s][ta]);
        check({tag, "_mem_b"}, peek(s, tb_), ref_mem[s][tb_]);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b1;
            a_in[s]  = AW'($urandom_range(0, 31));
            b_in[s]  = AW'($urandom_range(0, 31));
        end

        // Reset held with start asserted: nothing may move.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_addr%0d", s), 32'(maddr[s]), 32'd0);
            check($sformatf("rst_wdata%0d", s), wdata[s], 32'd0);
            check($sformatf("rst_we%0d", s), 32'(we[s]), 32'd0);
            check($sformatf("rst_busy%0d", s), 32'(busy[s]), 32'd0);
            check($sformatf("rst_done%0d", s), 32'(done[s]), 32'd0);
            check($sformatf("rst_swapped%0d", s), 32'(swp[s]), 32'd0);
            start[s] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("post_rst_busy%0d", s), 32'(busy[s]), 32'd0);
            check($sformatf("post_rst_we%0d", s), 32'(we[s]), 32'd0);
        end

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                poke(s, i, ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 7)) : DW'($urandom));

        // Directed cases, ascending instance.
        poke(0, 3, 50); poke(0, 7, 20);
        run_op(0, 3, 7, 1'b0, "asc_swap");
        run_op(0, 3, 7, 1'b0, "asc_noswap");
        poke(0, 3, 9); poke(0, 7, 9);
        run_op(0, 3, 7, 1'b0, "asc_equal");
        run_op(0, 12, 12, 1'b0, "asc_same_addr");
        poke(0, 0, 32'hFFFF_FFFF); poke(0, 31, 0);
        run_op(0, 0, 31, 1'b0, "asc_unsigned");
        check("asc_unsigned_m0", peek(0, 0), 32'd0);
        check("asc_unsigned_m31", peek(0, 31), 32'hFFFF_FFFF);

        // Directed case, descending instance.
        poke(1, 1, 4); poke(1, 2, 9);
        run_op(1, 1, 2, 1'b0, "desc_swap");
        check("desc_swap_m1", peek(1, 1), 32'd9);
        check("desc_swap_m2", peek(1, 2), 32'd4);

        // Start pulses while busy are ignored; the next op follows back-to-back.
        poke(0, 4, 77); poke(0, 5, 11);
        run_op(0, 4, 5, 1'b1, "junk_swap");
        run_op(0, 6, 8, 1'b1, "b2b_follow");

        // Randomised pairs on both instances, issued back-to-back.
        for (int n = 0; n < 40; n++)
            run_op(n % 2, $urandom_range(0, 31), $urandom_range(0, 31), ($urandom_range(0, 3) == 0),
                   $sformatf("rnd%0d", n));

        // Reset during WR_B: first write has landed, second must not.
        poke(0, 20, 100); poke(0, 21, 1);
        @(negedge clk);
        start[0] = 1'b1; a_in[0] = AW'(20); b_in[0] = AW'(21);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_we_before", 32'(we[0]), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_we", 32'(we[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_swapped", 32'(swp[0]), 32'd0);
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (done[0] === 1'b1) seen_done++;
            end
            rst = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (done[0] === 1'b1) seen_done++;
            end
            check("midrst_no_done", 32'(seen_done), 32'd0);
        end
        check("midrst_mem_a", peek(0, 20), 32'd1);
        check("midrst_mem_b", peek(0, 21), 32'd1);
        ref_mem[0][20] = 1;

        run_op(0, 21, 20, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
